// File: rtl/bits2bytes_pkg.sv
// Shared types and helpers for the bits2bytes_packer slice.
// The chunk-count helper is also used by the testbench so both sides agree on the word shape.
package bits2bytes_pkg;

    typedef enum logic [1:0] {IDLE, FILL, EMIT} b2b_state_e;

    function automatic int chunks(input int n_bytes, input int in_bits);
        return (n_bytes * 8) / in_bits;
    endfunction

endpackage

// File: rtl/bits2bytes_packer_if.sv
// Chunk-input / word-output handshake bundle for bits2bytes_packer.
// in_last and out_last exist only when BITS2BYTES_PACKER_LAST_EN is defined.
interface bits2bytes_packer_if #(
    parameter int N_BYTES = 4,
    parameter int IN_BITS = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_BITS-1:0]      in_bits;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_BYTES-1:0][7:0] out_bytes;
    logic                    busy;
`ifdef BITS2BYTES_PACKER_LAST_EN
    logic                    in_last;
    logic                    out_last;

    modport master (
        output in_valid, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_bytes, out_last, busy
    );

    modport slave (
        input  in_valid, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_bytes, out_last, busy
    );
`else
    modport master (
        output in_valid, in_bits, out_ready,
        input  in_ready, out_valid, out_bytes, busy
    );

    modport slave (
        input  in_valid, in_bits, out_ready,
        output in_ready, out_valid, out_bytes, busy
    );
`endif
endinterface

// File: rtl/bits2bytes.sv
// Combinational view of a flat N_BYTES*8-bit word as a byte array; byte i = bits [i*8 +: 8].
module bits2bytes #(
    parameter int N_BYTES = 4
) (
    input  logic [N_BYTES*8-1:0]    bits_i,
    output logic [N_BYTES-1:0][7:0] bytes_o
);

    for (genvar i = 0; i < N_BYTES; i++) begin : g_byte
        assign bytes_o[i] = bits_i[i*8 +: 8];
    end

endmodule

// File: rtl/bits2bytes_packer.sv
// Accumulates IN_BITS chunks LSB-first into an N_BYTES word and offers it as a byte array.
// Optional early word termination via in_last/out_last when BITS2BYTES_PACKER_LAST_EN is defined.
module bits2bytes_packer
    import bits2bytes_pkg::*;
#(
    parameter int N_BYTES = 4,
    parameter int IN_BITS = 8
) (
    input logic                clk,
    input logic                rst,
    bits2bytes_packer_if.slave bus
);

    localparam int W_BITS = N_BYTES * 8;
    localparam int CHUNKS = chunks(N_BYTES, IN_BITS);
    localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    if ((W_BITS % IN_BITS) != 0) begin : g_bad_cfg
        $fatal(1, "bits2bytes_packer: IN_BITS (%0d) must divide N_BYTES*8 (%0d)", IN_BITS, W_BITS);
    end

    b2b_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [W_BITS-1:0]       buf_q, buf_d;
    logic [N_BYTES-1:0][7:0] word_bytes;
    logic                    accept;
    logic                    close_word;
`ifdef BITS2BYTES_PACKER_LAST_EN
    logic                    last_q, last_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
`ifdef BITS2BYTES_PACKER_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
`ifdef BITS2BYTES_PACKER_LAST_EN
            last_q  <= last_d;
`endif
        end
    end

    // The counter stays on the closing chunk while in EMIT; the handshake clears it with the buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        accept  = bus.in_valid && (state_q != EMIT);
`ifdef BITS2BYTES_PACKER_LAST_EN
        last_d     = last_q;
        close_word = (cnt_q == CNT_W'(CHUNKS - 1)) || bus.in_last;
`else
        close_word = (cnt_q == CNT_W'(CHUNKS - 1));
`endif
        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    buf_d[cnt_q*IN_BITS +: IN_BITS] = bus.in_bits;
                    if (close_word) begin
                        state_d = EMIT;
`ifdef BITS2BYTES_PACKER_LAST_EN
                        last_d  = bus.in_last;
`endif
                    end else begin
                        state_d = FILL;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    buf_d   = '0;
`ifdef BITS2BYTES_PACKER_LAST_EN
                    last_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    bits2bytes #(
        .N_BYTES (N_BYTES)
    ) u_bits2bytes (
        .bits_i  (buf_q),
        .bytes_o (word_bytes)
    );

    // in_ready is forced low while reset is asserted so no chunk is offered into a clearing packer.
    always_comb begin
        bus.in_ready  = !rst && (state_q != EMIT);
        bus.out_valid = (state_q == EMIT);
        bus.busy      = (state_q != IDLE);
        bus.out_bytes = word_bytes;
`ifdef BITS2BYTES_PACKER_LAST_EN
        bus.out_last  = last_q;
`endif
    end

endmodule

// File: tb/tb_bits2bytes_packer.sv
// Bench for bits2bytes_packer: directed scenarios plus randomized streams scored against a chunk-queue model.
// Define BITS2BYTES_PACKER_LAST_EN to also exercise in_last/out_last.
module tb_bits2bytes_packer;
    import bits2bytes_pkg::*;

    localparam int NB  = 4;
    localparam int CH8 = chunks(NB, 8);
    localparam int CH4 = chunks(NB, 4);

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    bits2bytes_packer_if #(.N_BYTES(NB), .IN_BITS(8)) bus8 ();
    bits2bytes_packer_if #(.N_BYTES(NB), .IN_BITS(4)) bus4 ();

    bits2bytes_packer #(.N_BYTES(NB), .IN_BITS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    bits2bytes_packer #(.N_BYTES(NB), .IN_BITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    // Offers one 8-bit chunk from a negedge and returns at the negedge after the accepting edge.
    task automatic push8(input logic [7:0] b);
        bus8.in_valid = 1'b1;
        bus8.in_bits  = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_bits = '0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_bits = '0; bus4.out_ready = 1'b0;
`ifdef BITS2BYTES_PACKER_LAST_EN
        bus8.in_last = 1'b0; bus4.in_last = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready_during_rst: got %b expected 0", bus8.in_ready); end
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus8.out_valid); end
        n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus8.busy); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready_after: got %b expected 1", bus8.in_ready); end
        n_cmp++; if (bus8.out_bytes !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_out_bytes: got %h expected 00000000", bus8.out_bytes); end
        n_cmp++; if (bus4.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_in_ready_nibble: got %b expected 1", bus4.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_full_word();
        logic [7:0] exp_b [4];
        exp_b = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
        bus8.out_ready = 1'b1;
        push8(8'hEF); push8(8'hCD); push8(8'hAB);
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL full_early_valid: got %b expected 0", bus8.out_valid); end
        n_cmp++; if (bus8.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL full_busy_fill: got %b expected 1", bus8.busy); end
        push8(8'h89);
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL full_out_valid: got %b expected 1", bus8.out_valid); end
        n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL full_in_ready_emit: got %b expected 0", bus8.in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus8.out_bytes[i] !== exp_b[i]) begin n_bad++; $display("[TB] FAIL full_byte%0d: got %h expected %h", i, bus8.out_bytes[i], exp_b[i]); end
        end
        @(negedge clk);
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL full_valid_after: got %b expected 0", bus8.out_valid); end
        n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL full_ready_after: got %b expected 1", bus8.in_ready); end
        n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL full_busy_after: got %b expected 0", bus8.busy); end
        n_cmp++; if (bus8.out_bytes !== 32'h0) begin n_bad++; $display("[TB] FAIL full_bytes_cleared: got %h expected 00000000", bus8.out_bytes); end
    endtask

    task automatic test_backpressure();
        bus8.out_ready = 1'b0;
        push8(8'hEF); push8(8'hCD); push8(8'hAB); push8(8'h89);
        bus8.in_bits = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_valid_c%0d: got %b expected 1", c, bus8.out_valid); end
            n_cmp++; if (bus8.out_bytes !== 32'h89ABCDEF) begin n_bad++; $display("[TB] FAIL bp_bytes_c%0d: got %h expected 89abcdef", c, bus8.out_bytes); end
            n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_in_ready_c%0d: got %b expected 0", c, bus8.in_ready); end
            @(negedge clk);
        end
        bus8.out_ready = 1'b1;
        n_cmp++; if (bus8.out_bytes !== 32'h89ABCDEF) begin n_bad++; $display("[TB] FAIL bp_bytes_hs: got %h expected 89abcdef", bus8.out_bytes); end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_ready_after: got %b expected 1", bus8.in_ready); end
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_valid_after: got %b expected 0", bus8.out_valid); end
        n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_busy_after: got %b expected 0", bus8.busy); end
    endtask

    task automatic test_gapped();
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push8(8'(k + 1));
            if (k < 3) begin
                bus8.in_valid = 1'b0;
                bus8.in_bits  = 8'hFF;
                @(negedge clk);
                n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL gap_valid_k%0d: got %b expected 0", k, bus8.out_valid); end
            end
        end
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL gap_out_valid: got %b expected 1", bus8.out_valid); end
        n_cmp++; if (bus8.out_bytes !== 32'h04030201) begin n_bad++; $display("[TB] FAIL gap_word: got %h expected 04030201", bus8.out_bytes); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        bus8.out_ready = 1'b1;
        push8(8'hAA); push8(8'hBB);
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_fill_busy_before: got %b expected 1", bus8.busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_fill_busy: got %b expected 0", bus8.busy); end
        n_cmp++; if (bus8.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_fill_in_ready: got %b expected 0", bus8.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (bus8.out_bytes !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_fill_bytes: got %h expected 00000000", bus8.out_bytes); end
        push8(8'h11); push8(8'h22); push8(8'h33); push8(8'h44);
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_fill_valid: got %b expected 1", bus8.out_valid); end
        n_cmp++; if (bus8.out_bytes !== 32'h44332211) begin n_bad++; $display("[TB] FAIL rst_fill_word: got %h expected 44332211", bus8.out_bytes); end
        @(negedge clk);
        // A reset while a word waits for the consumer drops it.
        bus8.out_ready = 1'b0;
        push8(8'h01); push8(8'h02); push8(8'h03); push8(8'h04);
        bus8.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus8.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_emit_valid: got %b expected 0", bus8.out_valid); end
        n_cmp++; if (bus8.out_bytes !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_emit_bytes: got %h expected 00000000", bus8.out_bytes); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q[$];
        logic [31:0] exp_word;
        bit          pending = 1'b0;
        int          last_emit = -1;
        int          words = 0;
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 3 * (CH8 + 1); cyc++) begin
            bus8.in_bits = 8'($urandom);
            n_cmp++; if (bus8.in_ready !== !pending) begin n_bad++; $display("[TB] FAIL b2b_in_ready_c%0d: got %b expected %b", cyc, bus8.in_ready, !pending); end
            n_cmp++; if (bus8.out_valid !== pending) begin n_bad++; $display("[TB] FAIL b2b_out_valid_c%0d: got %b expected %b", cyc, bus8.out_valid, pending); end
            if (pending) begin
                exp_word = '0;
                for (int k = 0; k < CH8; k++) exp_word |= 32'(q[k]) << (8 * k);
                n_cmp++; if (bus8.out_bytes !== exp_word) begin n_bad++; $display("[TB] FAIL b2b_word_c%0d: got %h expected %h", cyc, bus8.out_bytes, exp_word); end
                if (last_emit >= 0) begin
                    n_cmp++; if (cyc - last_emit !== CH8 + 1) begin n_bad++; $display("[TB] FAIL b2b_spacing: got %0d expected %0d", cyc - last_emit, CH8 + 1); end
                end
                last_emit = cyc;
                words++;
                q.delete();
                pending = 1'b0;
            end else begin
                q.push_back(bus8.in_bits);
                if (q.size() == CH8) pending = 1'b1;
            end
            @(negedge clk);
        end
        bus8.in_valid = 1'b0;
        n_cmp++; if (words !== 3) begin n_bad++; $display("[TB] FAIL b2b_word_count: got %0d expected 3", words); end
    endtask

    task automatic test_nibble_stream();
        logic [3:0]  q[$];
        logic [31:0] exp_word;
        bit          pending = 1'b0;
        int          last_emit = -1;
        int          words = 0;
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 3 * (CH4 + 1); cyc++) begin
            bus4.in_bits = 4'($urandom);
            n_cmp++; if (bus4.out_valid !== pending) begin n_bad++; $display("[TB] FAIL nib_out_valid_c%0d: got %b expected %b", cyc, bus4.out_valid, pending); end
            if (pending) begin
                exp_word = '0;
                for (int k = 0; k < CH4; k++) exp_word |= 32'(q[k]) << (4 * k);
                n_cmp++; if (bus4.out_bytes !== exp_word) begin n_bad++; $display("[TB] FAIL nib_word_c%0d: got %h expected %h", cyc, bus4.out_bytes, exp_word); end
                if (last_emit >= 0) begin
                    n_cmp++; if (cyc - last_emit !== CH4 + 1) begin n_bad++; $display("[TB] FAIL nib_spacing: got %0d expected %0d", cyc - last_emit, CH4 + 1); end
                end
                last_emit = cyc;
                words++;
                q.delete();
                pending = 1'b0;
            end else begin
                q.push_back(bus4.in_bits);
                if (q.size() == CH4) pending = 1'b1;
            end
            @(negedge clk);
        end
        bus4.in_valid = 1'b0;
        n_cmp++; if (words !== 3) begin n_bad++; $display("[TB] FAIL nib_word_count: got %0d expected 3", words); end
    endtask

    task automatic test_random();
        logic [7:0]  q[$];
        logic [31:0] exp_word;
        bit          pending = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            bus8.in_valid  = 1'($urandom_range(0, 1));
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            bus8.in_bits   = 8'($urandom);
            n_cmp++; if (bus8.in_ready !== !pending) begin n_bad++; $display("[TB] FAIL rnd_in_ready_c%0d: got %b expected %b", cyc, bus8.in_ready, !pending); end
            n_cmp++; if (bus8.out_valid !== pending) begin n_bad++; $display("[TB] FAIL rnd_out_valid_c%0d: got %b expected %b", cyc, bus8.out_valid, pending); end
            if (pending) begin
                exp_word = '0;
                for (int k = 0; k < CH8; k++) exp_word |= 32'(q[k]) << (8 * k);
                n_cmp++; if (bus8.out_bytes !== exp_word) begin n_bad++; $display("[TB] FAIL rnd_word_c%0d: got %h expected %h", cyc, bus8.out_bytes, exp_word); end
                if (bus8.out_ready) begin
                    q.delete();
                    pending = 1'b0;
                end
            end else if (bus8.in_valid) begin
                q.push_back(bus8.in_bits);
                if (q.size() == CH8) pending = 1'b1;
            end
            @(negedge clk);
        end
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus8.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rnd_final_reset_busy: got %b expected 0", bus8.busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef BITS2BYTES_PACKER_LAST_EN
    task automatic test_last();
        bus8.out_ready = 1'b1;
        bus8.in_last = 1'b0; push8(8'h11);
        bus8.in_last = 1'b1; push8(8'h22);
        bus8.in_valid = 1'b0; bus8.in_last = 1'b0;
        n_cmp++; if (bus8.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL last_short_valid: got %b expected 1", bus8.out_valid); end
        n_cmp++; if (bus8.out_bytes !== 32'h00002211) begin n_bad++; $display("[TB] FAIL last_short_word: got %h expected 00002211", bus8.out_bytes); end
        n_cmp++; if (bus8.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL last_short_flag: got %b expected 1", bus8.out_last); end
        @(negedge clk);
        n_cmp++; if (bus8.out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL last_flag_cleared: got %b expected 0", bus8.out_last); end
        push8(8'hA1); push8(8'hB2); push8(8'hC3); push8(8'hD4);
        bus8.in_valid = 1'b0;
        n_cmp++; if (bus8.out_bytes !== 32'hD4C3B2A1) begin n_bad++; $display("[TB] FAIL last_full_word: got %h expected d4c3b2a1", bus8.out_bytes); end
        n_cmp++; if (bus8.out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL last_full_flag: got %b expected 0", bus8.out_last); end
        @(negedge clk);
        push8(8'h01); push8(8'h02); push8(8'h03);
        bus8.in_last = 1'b1; push8(8'h04);
        bus8.in_valid = 1'b0; bus8.in_last = 1'b0;
        n_cmp++; if (bus8.out_bytes !== 32'h04030201) begin n_bad++; $display("[TB] FAIL last_on_final_word: got %h expected 04030201", bus8.out_bytes); end
        n_cmp++; if (bus8.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL last_on_final_flag: got %b expected 1", bus8.out_last); end
        @(negedge clk);
        bus8.in_last = 1'b1; push8(8'h7E);
        bus8.in_valid = 1'b0; bus8.in_last = 1'b0;
        n_cmp++; if (bus8.out_bytes !== 32'h0000007E) begin n_bad++; $display("[TB] FAIL last_single_word: got %h expected 0000007e", bus8.out_bytes); end
        n_cmp++; if (bus8.out_last !== 1'b1) begin n_bad++; $display("[TB] FAIL last_single_flag: got %b expected 1", bus8.out_last); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_gapped();
        test_reset_mid_fill();
        test_back_to_back();
        test_nibble_stream();
        test_random();
`ifdef BITS2BYTES_PACKER_LAST_EN
        test_last();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bits2bytes_packer.md
# bits2bytes_packer

Streaming packer that accepts narrow bit chunks over a valid/ready handshake and accumulates them into one N_BYTES-wide word. It presents the word through the combinational bits2bytes converter as a byte array on a second valid/ready port. It sits between the serial bit producers of the encode path and the byte-oriented consumers.

## Interface
- N_BYTES, 4, bytes per output word
- IN_BITS, 8, bits per input chunk; must divide N_BYTES*8 (elaboration-time check, $fatal otherwise)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input chunk valid
- in_ready  out  1  packer can accept a chunk
- in_bits  in  IN_BITS  input chunk
- in_last  in  1  final chunk of message (only with BITS2BYTES_PACKER_LAST_EN)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts word
- out_bytes  out  [N_BYTES-1:0][7:0]  packed word; byte i = word bits [i*8 +: 8]
- out_last  out  1  word ends message (only with BITS2BYTES_PACKER_LAST_EN)
- busy  out  1  partial or full word held

## Operation
- CHUNKS = N_BYTES*8/IN_BITS; chunk counter width $clog2(CHUNKS), minimum 1 bit.
- Chunk k of a word is written to buffer bits [k*IN_BITS +: IN_BITS], LSB-first. The first accepted chunk lands in the low bits.
- Accept = in_valid && in_ready. Beats with in_valid low are ignored, and the counter holds.
- FSM states:
  - IDLE: counter 0, buffer 0, in_ready=1. Accept goes to FILL, or to EMIT if CHUNKS==1.
  - FILL: in_ready=1. Accept with counter==CHUNKS-1 goes to EMIT, else counter+1.
  - EMIT: in_ready=0, out_valid=1. out_valid && out_ready clears buffer and counter and goes to IDLE.
- In EMIT with out_ready low, out_valid, out_bytes and out_last hold stable.
- There is no input/output overlap. Input is stalled for exactly the EMIT cycles.
- busy = (state != IDLE).
- Reset (any time, including mid-FILL or mid-EMIT):
  - State goes to IDLE, counter and buffer to 0.
  - out_valid=0, out_last=0, busy=0, in_ready=1 after reset deasserts. in_ready is 0 while rst is high.
  - Any partial word is discarded.

## Timing
- Last chunk of a word accepted at edge t: out_valid=1 in the cycle after t.
- Output accepted at edge u: in_ready=1 in the cycle after u.
- Sustained throughput with in_valid and out_ready held high: one word per CHUNKS+1 cycles.
- out_bytes is combinational from the registered buffer. It is 0 out of reset and after each emit, and only meaningful while out_valid=1.

## Configuration
- BITS2BYTES_PACKER_LAST_EN defined:
  - The in_last and out_last ports exist.
  - Accept with in_last=1 from any state goes to EMIT immediately. Unfilled chunks stay 0 (zero padding).
  - out_last=1 for that word and clears on its handshake.
  - in_last on the CHUNKS-th chunk behaves as a normal full word with out_last=1.
- Macro undefined:
  - The ports are absent.
  - Words are emitted only when full.

## Structure
- Package bits2bytes_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, EMIT} b2b_state_e
  - function chunks(n_bytes, in_bits) returning the chunk count, shared with the testbench
- One sub-module: bits2bytes (N_BYTES), instantiated with bits_i = buffer and bytes_o = out_bytes.
- FSM, counter and buffer live in the packer.

## Test plan (N_BYTES=4, IN_BITS=8 unless noted)
- Full word: chunks EF, CD, AB, 89 with out_ready=1 -> out_valid one cycle after the 89 accept, out_bytes[0..3]=EF, CD, AB, 89, then IDLE.
- Backpressure: same word with out_ready=0 for 3 cycles -> out_valid and out_bytes stable, in_ready=0 throughout; handshake on cycle 4 -> in_ready=1 next cycle.
- Gapped input: in_valid toggled 1,0,1,0 over chunks 01..04 -> only the 4 valid beats are counted; word = 04030201.
- Streaming: 3 words back-to-back, in_valid and out_ready high -> out_valid pulses every 5 cycles with the correct data. Repeat with IN_BITS=4 -> 9-cycle spacing.
- Reset mid-fill: 2 chunks AA, BB accepted, rst pulsed -> busy=0; next chunks 11, 22, 33, 44 -> word 44332211 with no AA/BB residue.
- LAST_EN: chunks 11, 22 with in_last on 22 -> out_bytes=00, 00, 22, 11 (bytes 3..0) and out_last=1. A following full word has out_last=0.
